// File: rtl/ram_operand_seq_if.sv
// RAM-side bus of the operand sequencer: one outstanding request, completed by mem_ack.
interface ram_operand_seq_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/ram_operand_seq.sv
// Fetches RAM-resident source operands and writes back a RAM-resident destination, holding the
// pipeline meanwhile. Define ACK_TIMEOUT_EN to abort requests left unacknowledged for TIMEOUT_CYC.
module ram_operand_seq #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    start_i,
    input  logic [4:0]              rs1_i,
    input  logic [4:0]              rs2_i,
    input  logic [4:0]              rd_i,
    input  logic                    use_rs1_i,
    input  logic                    use_rs2_i,
    input  logic                    rd_we_i,
    input  logic [31:0]             wdata_i,
    ram_operand_seq_if.master       mem_io,
    output logic                    stall_o,
    output logic [31:0]             op1_o,
    output logic [31:0]             op2_o,
    output logic                    op_valid_o,
    output logic                    err_o
);

    typedef enum logic [2:0] {StIdle, StRdRs1, StRdRs2, StWrRd, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  rs1_addr_q, rs2_addr_q, rd_addr_q;
    logic        need_rs2_q, need_wr_q;
    logic [31:0] wdata_q;
    logic [31:0] op1_q, op1_d, op2_q, op2_d;
    logic        accept;

    // First access still outstanding, in fixed RS1 -> RS2 -> RD order.
    function automatic state_e next_access(input logic n1, input logic n2, input logic nw);
        if (n1)      return StRdRs1;
        else if (n2) return StRdRs2;
        else if (nw) return StWrRd;
        else         return StDone;
    endfunction

    assign accept = (state_q == StIdle) && start_i;

`ifdef ACK_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            timeout;

    assign timeout = (cnt_q == CntW'(TIMEOUT_CYC - 1)) && !mem_io.mem_ack;
    assign err_o   = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign err_o          = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        op1_d            = op1_q;
        op2_d            = op2_q;
        mem_io.mem_req   = 1'b0;
        mem_io.mem_we    = 1'b0;
        mem_io.mem_addr  = 4'h0;
        mem_io.mem_wdata = 32'h0;
        op_valid_o       = 1'b0;
`ifdef ACK_TIMEOUT_EN
        err_d            = err_q;
        cnt_d            = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = next_access(use_rs1_i & rs1_i[4], use_rs2_i & rs2_i[4],
                                          rd_we_i & rd_i[4]);
                    op1_d   = 32'h0;
                    op2_d   = 32'h0;
`ifdef ACK_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            StRdRs1, StRdRs2: begin
                mem_io.mem_req  = 1'b1;
                mem_io.mem_addr = (state_q == StRdRs1) ? rs1_addr_q : rs2_addr_q;
                if (mem_io.mem_ack) begin
                    if (state_q == StRdRs1) begin
                        op1_d   = mem_io.mem_rdata;
                        state_d = next_access(1'b0, need_rs2_q, need_wr_q);
                    end else begin
                        op2_d   = mem_io.mem_rdata;
                        state_d = next_access(1'b0, 1'b0, need_wr_q);
                    end
                end
`ifdef ACK_TIMEOUT_EN
                else if (timeout) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                end
`endif
            end
            StWrRd: begin
                mem_io.mem_req   = 1'b1;
                mem_io.mem_we    = 1'b1;
                mem_io.mem_addr  = rd_addr_q;
                mem_io.mem_wdata = wdata_q;
                if (mem_io.mem_ack) begin
                    state_d = StDone;
                end
`ifdef ACK_TIMEOUT_EN
                else if (timeout) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                end
`endif
            end
            StDone: begin
                op_valid_o = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign stall_o = (state_q != StIdle);
    assign op1_o   = op1_q;
    assign op2_o   = op2_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            op1_q   <= 32'h0;
            op2_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

    // Instruction fields are captured only when a start is accepted.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rs1_addr_q <= 4'h0;
            rs2_addr_q <= 4'h0;
            rd_addr_q  <= 4'h0;
            need_rs2_q <= 1'b0;
            need_wr_q  <= 1'b0;
            wdata_q    <= 32'h0;
        end else if (accept) begin
            rs1_addr_q <= rs1_i[3:0];
            rs2_addr_q <= rs2_i[3:0];
            rd_addr_q  <= rd_i[3:0];
            need_rs2_q <= use_rs2_i & rs2_i[4];
            need_wr_q  <= rd_we_i & rd_i[4];
            wdata_q    <= wdata_i;
        end
    end

`ifdef ACK_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_ram_operand_seq.sv
// Bench for ram_operand_seq: builds the expected per-cycle trace of each instruction from its
// access list and the responder's wait counts, and compares the DUT against it every cycle.
module tb_ram_operand_seq;
    localparam int unsigned TO_CYC = 16;

    typedef struct {
        logic        stall, req, we, opv, err;
        logic [3:0]  addr;
        logic [31:0] wdata, op1, op2;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        use_rs1 = 1'b0, use_rs2 = 1'b0, rd_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        stall, op_valid, err;
    logic [31:0] op1, op2;

    ram_operand_seq_if mem_bus ();

    ram_operand_seq #(.TIMEOUT_CYC(TO_CYC)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start_i   (start),
        .rs1_i     (rs1),
        .rs2_i     (rs2),
        .rd_i      (rd),
        .use_rs1_i (use_rs1),
        .use_rs2_i (use_rs2),
        .rd_we_i   (rd_we),
        .wdata_i   (wdata),
        .mem_io    (mem_bus.master),
        .stall_o   (stall),
        .op1_o     (op1),
        .op2_o     (op2),
        .op_valid_o(op_valid),
        .err_o     (err)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    int          resp_q[$];
    logic [31:0] ram[16];
    logic [31:0] hop1 = '0, hop2 = '0;
    logic        herr = 1'b0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          opv_cyc = 0;
    int          opv_cnt = 0;
    int          rcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic st, input logic rq, input logic w, input logic ov,
                                input logic er, input logic [3:0] a, input logic [31:0] wd,
                                input logic [31:0] o1, input logic [31:0] o2);
        exp_t e;
        e.stall = st; e.req = rq; e.we = w; e.opv = ov; e.err = er;
        e.addr = a; e.wdata = wd; e.op1 = o1; e.op2 = o2;
        return e;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // RAM responder: acks after the queued number of wait cycles (negative = never).
    always @(negedge CLK) begin
        if (mem_bus.mem_req) begin
            if (rcnt == ((resp_q.size() > 0) ? resp_q[0] : 0)) begin
                mem_bus.mem_ack = 1'b1;
                if (mem_bus.mem_we) ram[mem_bus.mem_addr] = mem_bus.mem_wdata;
                else                mem_bus.mem_rdata = ram[mem_bus.mem_addr];
                if (resp_q.size() > 0) void'(resp_q.pop_front());
                rcnt = 0;
            end else begin
                mem_bus.mem_ack   = 1'b0;
                mem_bus.mem_rdata = 32'h0BAD_0BAD;
                rcnt++;
            end
        end else begin
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = 32'h0BAD_0BAD;
            rcnt = 0;
        end
    end

    // Compare process: one trace entry per cycle, otherwise idle with held operands.
    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            hop1 = e.op1;
            hop2 = e.op2;
            herr = e.err;
        end else begin
            e = mk(1'b0, 1'b0, 1'b0, 1'b0, herr, 4'h0, 32'h0, hop1, hop2);
        end
        chk("stall", 32'(stall), 32'(e.stall));
        chk("mem_req", 32'(mem_bus.mem_req), 32'(e.req));
        chk("mem_we", 32'(mem_bus.mem_we), 32'(e.we));
        if (e.req) chk("mem_addr", 32'(mem_bus.mem_addr), 32'(e.addr));
        if (e.req && e.we) chk("mem_wdata", mem_bus.mem_wdata, e.wdata);
        chk("op_valid", 32'(op_valid), 32'(e.opv));
        chk("op1", op1, e.op1);
        chk("op2", op2, e.op2);
        chk("err", 32'(err), 32'(e.err));
        if (op_valid) begin
            opv_cnt++;
            opv_cyc = cyc;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                         input logic u1, input logic u2, input logic we, input logic [31:0] wd,
                         input int w1, input int w2, input int w3);
        exp_t        tr[$];
        logic [31:0] o1 = '0, o2 = '0;
        logic [4:0]  addrs[3];
        logic        need[3];
        int          ws[3];
        logic        aborted = 1'b0;
        addrs = '{r1, r2, rdd};
        need  = '{u1 & r1[4], u2 & r2[4], we & rdd[4]};
        ws    = '{w1, w2, w3};
        for (int k = 0; k < 3; k++) begin
            if (need[k] && !aborted) begin
                resp_q.push_back(ws[k]);
                for (int c = 0; c < ((ws[k] < 0) ? int'(TO_CYC) : ws[k] + 1); c++)
                    tr.push_back(mk(1'b1, 1'b1, k == 2, 1'b0, 1'b0, addrs[k][3:0], wd, o1, o2));
                if (ws[k] < 0) begin
                    tr.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0, o1, o2));
                    aborted = 1'b1;
                end else if (k == 0) o1 = ram[r1[3:0]];
                else if (k == 1)     o2 = ram[r2[3:0]];
            end
        end
        if (!aborted) tr.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, o1, o2));
        rs1 = r1; rs2 = r2; rd = rdd; use_rs1 = u1; use_rs2 = u2; rd_we = we; wdata = wd;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start      = 1'b0;
        accept_cyc = cyc;
        foreach (tr[i]) exp_q.push_back(tr[i]);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("trace_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'h5A00_0000 + 32'(i);
        ram[1]  = 32'h1111_0001;
        ram[2]  = 32'hDEAD_BEEF;
        ram[15] = 32'hFFFF_000F;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;

        // No RAM operands; start is taken on the first edge after reset release.
        opv_cnt = 0;
        issue(5'h03, 5'h07, 5'h00, 1'b1, 1'b1, 1'b0, 32'h0, 0, 0, 0);
        wait_done();
        chk("lat_no_access", 32'(opv_cyc - accept_cyc + 1), 32'd1);
        chk("opv_cnt_033", 32'(opv_cnt), 32'd1);

        // Single read of word 2 with two wait cycles.
        opv_cnt = 0;
        issue(5'h12, 5'h05, 5'h00, 1'b1, 1'b1, 1'b0, 32'h0, 2, 0, 0);
        wait_done();
        chk("op1_034", op1, 32'hDEAD_BEEF);
        chk("op2_034", op2, 32'h0);
        chk("lat_034", 32'(opv_cyc - accept_cyc + 1), 32'd4);
        chk("opv_cnt_034", 32'(opv_cnt), 32'd1);

        // Two reads plus writeback, all acked immediately.
        opv_cnt = 0;
        issue(5'h11, 5'h1F, 5'h14, 1'b1, 1'b1, 1'b1, 32'h0000_00AA, 0, 0, 0);
        wait_done();
        chk("op1_035", op1, 32'h1111_0001);
        chk("op2_035", op2, 32'hFFFF_000F);
        chk("lat_035", 32'(opv_cyc - accept_cyc + 1), 32'd4);
        chk("ram4_035", ram[4], 32'h0000_00AA);

        // Mixed waits; rd outside RAM so no write.
        opv_cnt = 0;
        issue(5'h1A, 5'h1B, 5'h04, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1, 3, 0);
        wait_done();
        chk("op1_mix", op1, 32'h5A00_000A);
        chk("lat_mix", 32'(opv_cyc - accept_cyc + 1), 32'd7);

        // Second start during RD_RS1 is ignored.
        opv_cnt = 0;
        issue(5'h13, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0, 32'h0, 3, 0, 0);
        rs1 = 5'h1E; rs2 = 5'h1D; use_rs2 = 1'b1; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        wait_done();
        chk("opv_cnt_036", 32'(opv_cnt), 32'd1);
        chk("op1_036", op1, 32'h5A00_0003);
        chk("op2_036", op2, 32'h0);

        // Asynchronous reset while waiting in RD_RS2.
        issue(5'h11, 5'h16, 5'h00, 1'b1, 1'b1, 1'b0, 32'h0, 0, 50, 0);
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        exp_q.delete();
        resp_q.delete();
        hop1 = '0; hop2 = '0; herr = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_bus.mem_req), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_op1", op1, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        opv_cnt = 0;
        issue(5'h01, 5'h1F, 5'h00, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0, 0);
        wait_done();
        chk("op2_after_rst", op2, 32'hFFFF_000F);
        chk("opv_cnt_rst", 32'(opv_cnt), 32'd1);

`ifdef ACK_TIMEOUT_EN
        // Never-acked read aborts after TO_CYC request cycles.
        opv_cnt = 0;
        issue(5'h10, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0, 32'h0, -1, 0, 0);
        wait_done();
        resp_q.delete();
        chk("err_038", 32'(err), 32'h1);
        chk("opv_cnt_038", 32'(opv_cnt), 32'd0);
        issue(5'h00, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 0);
        wait_done();
        chk("err_cleared", 32'(err), 32'h0);
`endif

        repeat (2) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
